// File: rtl/rr_skid_arbiter.sv
// Round-robin arbiter feeding one valid/ready output channel through a
// main register plus a one-entry skid register (registered upstream stall).
module rr_skid_arbiter #(
   parameter int N  = 4,
   parameter int W  = 16,
   parameter int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   in_valid,
   input  logic [N*W-1:0] in_data,
   output logic [N-1:0]   in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_src,
   input  logic           out_ready
);

   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] grant_idx;
   logic [SW-1:0] next_ptr;
   logic          grant_found;
   logic [W-1:0]  grant_data;
   logic          accept;
   logic          pop;
   logic          skid_valid;
   logic [W-1:0]  skid_data;
   logic [SW-1:0] skid_src;

   // Search starts at rr_ptr and wraps, so the last winner becomes lowest priority.
   always_comb begin : arbitrate
      int cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < N; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!grant_found && in_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = SW'(cand);
         end
      end
   end

   always_comb begin
      grant_data = in_data[grant_idx*W +: W];
      next_ptr   = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
      accept     = grant_found && !skid_valid;
      pop        = out_valid && out_ready;
   end

   // Gated by reset so nothing can look accepted while the block is held in reset.
   always_comb begin
      in_ready = '0;
      if (reset && accept) begin
         in_ready[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= next_ptr;
      end
   end

   // Skid only fills while main is full and stalled; it always drains into main first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_src   <= '0;
      end else if (pop) begin
         if (skid_valid) begin
            out_data   <= skid_data;
            out_src    <= skid_src;
            skid_valid <= 1'b0;
         end else if (accept) begin
            out_data <= grant_data;
            out_src  <= grant_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!out_valid) begin
            out_data  <= grant_data;
            out_src   <= grant_idx;
            out_valid <= 1'b1;
         end else begin
            skid_data  <= grant_data;
            skid_src   <= grant_idx;
            skid_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rr_skid_arbiter.sv
// Bench for rr_skid_arbiter: hand vector table, directed sequences and random
// traffic against a queue-based reference model and per-requester scoreboard.
module tb_rr_skid_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int SW = 2;
   localparam logic [N*W-1:0] TBL_DATA = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

   typedef struct packed {
      logic [SW-1:0] src;
      logic [W-1:0]  data;
   } item_t;

   typedef struct {
      logic [N-1:0]  v;
      logic          r;
      logic [N-1:0]  rdy;
      logic          ov;
      logic [SW-1:0] src;
      logic [W-1:0]  data;
   } vec_t;

   logic           clk;
   logic           reset;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_src;
   logic           out_ready;

   int          vec_count = 0;
   int          miscompares = 0;
   int          produced = 0;
   int          consumed = 0;
   int          dut_accepts = 0;
   int          m_ptr = 0;
   item_t       m_q[$];
   item_t       sb[$];
   int          wait_cnt[N];
   logic        pend_v[N];
   logic [W-1:0] pend_d[N];
   int          seq_k[N];
   vec_t        tbl[14];

   rr_skid_arbiter #(.N(N), .W(W)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_src(out_src),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic clearModel();
      m_q.delete();
      sb.delete();
      m_ptr    = 0;
      produced = 0;
      consumed = 0;
      for (int i = 0; i < N; i++) begin
         wait_cnt[i] = 0;
         pend_v[i]   = 1'b0;
      end
   endtask

   task automatic doReset();
      in_valid  = '0;
      out_ready = 1'b0;
      reset     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      clearModel();
      @(posedge clk);
      #1;
   endtask

   // Fairness is judged from the DUT's own grants: no waiting requester may see N others win first.
   task automatic trackFairness(input logic [N-1:0] v);
      int g;
      g = -1;
      for (int i = 0; i < N; i++) begin
         if (in_ready[i]) g = i;
      end
      if (g >= 0) begin
         dut_accepts++;
         checkOutput("fairness", 32'(wait_cnt[g] < N), 32'd1);
         wait_cnt[g] = 0;
         for (int i = 0; i < N; i++) begin
            if (i != g && v[i]) wait_cnt[i]++;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!v[i]) wait_cnt[i] = 0;
      end
   endtask

   // One cycle: drive, compare against the model, clock, then advance the model.
   task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r, output int acc_idx);
      logic [N-1:0] exp_rdy;
      bit           found;
      bit           do_pop;
      bit           do_acc;
      int           g;
      int           j;
      int           hit;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
      found = 0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (!found && v[j]) begin
            found = 1;
            g     = j;
         end
      end
      exp_rdy = '0;
      if (found && m_q.size() < 2) exp_rdy[g] = 1'b1;
      checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
      checkOutput("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         checkOutput("out_data", 32'(out_data), 32'(m_q[0].data));
         checkOutput("out_src", 32'(out_src), 32'(m_q[0].src));
      end
      trackFairness(v);
      if (out_valid && out_ready) begin
         hit = -1;
         for (int i = 0; i < sb.size(); i++) begin
            if (hit < 0 && sb[i].src == out_src) hit = i;
         end
         consumed++;
         checkOutput("sb_present", 32'(hit >= 0), 32'd1);
         if (hit >= 0) begin
            checkOutput("sb_data", 32'(out_data), 32'(sb[hit].data));
            sb.delete(hit);
         end
      end
      do_pop  = (m_q.size() > 0) && r;
      do_acc  = found && (m_q.size() < 2);
      acc_idx = -1;
      @(posedge clk);
      if (do_pop) void'(m_q.pop_front());
      if (do_acc) begin
         m_q.push_back('{src: SW'(g), data: d[g*W +: W]});
         sb.push_back('{src: SW'(g), data: d[g*W +: W]});
         produced++;
         m_ptr   = (g + 1) % N;
         acc_idx = g;
      end
      #1;
   endtask

   task automatic runTraffic(input int cycles, input int vpct, input int rpct);
      logic [N-1:0]   v;
      logic [N*W-1:0] d;
      logic           r;
      int             a;
      for (int c = 0; c < cycles; c++) begin
         v = '0;
         d = '0;
         for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && int'($urandom_range(99)) < vpct) begin
               pend_v[i] = 1'b1;
               pend_d[i] = W'(i * 4096 + seq_k[i] % 4096);
            end
            v[i]         = pend_v[i];
            d[i*W +: W]  = pend_d[i];
         end
         r = (int'($urandom_range(99)) < rpct);
         applyStimulus(v, d, r, a);
         if (a >= 0) begin
            pend_v[a] = 1'b0;
            seq_k[a]++;
         end
      end
   endtask

   initial begin
      logic [N*W-1:0] d;
      int             a;
      int             k;
      int             c;
      int             acc0;

      tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
      tbl[1]  = '{4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 16'h0000};
      tbl[2]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd3, 16'h4444};
      tbl[3]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd0, 16'h1111};
      tbl[4]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 2'd1, 16'h2222};
      tbl[5]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h2222};
      tbl[6]  = '{4'b0011, 1'b1, 4'b0000, 1'b1, 2'd1, 16'h2222};
      tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 16'h1111};
      tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
      tbl[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 16'h0000};
      tbl[10] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd2, 16'h3333};
      tbl[11] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd0, 16'h1111};
      tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 16'h2222};
      tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000};

      for (int i = 0; i < N; i++) seq_k[i] = 0;
      clearModel();

      // Reset state, with requests pending while held in reset.
      reset     = 1'b0;
      in_valid  = 4'b1111;
      in_data   = TBL_DATA;
      out_ready = 1'b1;
      #2;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_out_src", 32'(out_src), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_hold_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_hold_ready", 32'(in_ready), 32'd0);
      doReset();

      // Table: handshakes, skid fill/drain, wrap-and-skip of rr_ptr.
      for (int t = 0; t < 14; t++) begin
         in_valid  = tbl[t].v;
         in_data   = TBL_DATA;
         out_ready = tbl[t].r;
         #1;
         checkOutput("tbl_in_ready", 32'(in_ready), 32'(tbl[t].rdy));
         checkOutput("tbl_out_valid", 32'(out_valid), 32'(tbl[t].ov));
         if (tbl[t].ov) begin
            checkOutput("tbl_out_src", 32'(out_src), 32'(tbl[t].src));
            checkOutput("tbl_out_data", 32'(out_data), 32'(tbl[t].data));
         end
         @(posedge clk);
         #1;
      end
      doReset();

      // Single requester 2, no backpressure.
      k = 0;
      c = 0;
      while (k < 8 && c < 40) begin
         d = '0;
         d[2*W +: W] = 16'h0300 + 16'(k);
         applyStimulus(4'b0100, d, 1'b1, a);
         if (a == 2) k++;
         c++;
      end
      checkOutput("single_count", 32'(k), 32'd8);
      repeat (2) applyStimulus('0, '0, 1'b1, a);

      // All four continuously valid, then a 5-cycle stall and recovery.
      runTraffic(12, 100, 100);
      acc0 = dut_accepts;
      runTraffic(5, 100, 0);
      checkOutput("stall_accepts", 32'(dut_accepts - acc0), 32'd1);
      runTraffic(8, 100, 100);

      // Asynchronous reset between edges with main and skid both full.
      runTraffic(3, 100, 0);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("async_out_valid", 32'(out_valid), 32'd0);
      checkOutput("async_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      in_valid = '0;
      @(negedge clk);
      reset = 1'b1;
      clearModel();
      @(posedge clk);
      #1;
      d = '0;
      d[1*W +: W] = 16'h1ABC;
      d[2*W +: W] = 16'h2ABC;
      applyStimulus(4'b0110, d, 1'b1, a);
      checkOutput("post_reset_ready", 32'(dut_accepts > 0), 32'd1);

      // Random stress, then drain.
      runTraffic(400, 70, 50);
      for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
      repeat (4) applyStimulus('0, '0, 1'b1, a);
      checkOutput("drain_counts", 32'(consumed), 32'(produced));
      checkOutput("drain_empty", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/rr_skid_arbiter.md
Name: rr_skid_arbiter

Overview:
- Round-robin arbiter that shares one skid-buffered valid/ready output channel among N requesters, e.g. functional-unit results contending for a single writeback/dispatch port.
- Each input is a valid/ready/data channel. The output is fully registered through a main register plus a one-entry skid register, which gives full throughput and a registered upstream stall.
- Sits between the producers and a single downstream consumer that may apply arbitrary backpressure.

Parameters:
- N, 4, number of requesters (N >= 2).
- W, 16, payload width in bits.
- SW, $clog2(N), width of the source-index field (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  N  per-requester valid.
- in_data  input  N*W  per-requester payload; requester i occupies bits [i*W +: W].
- in_ready  output  N  per-requester ready; at most one bit set in any cycle.
- out_valid  output  1  output payload valid.
- out_data  output  W  output payload.
- out_src  output  SW  index of the requester that produced out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_data=0, out_src=0, skid_valid=0, skid data/src=0, rr_ptr=0. in_ready is all zeros while reset=0.
- Arbitration is combinational:
  - The grant goes to the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo N.
  - No valid input means no grant.
- in_ready[i] = grant[i] && !skid_valid.
  - in_ready therefore depends combinationally on in_valid.
  - Requesters must hold valid and data stable until accepted.
- accept = any in_valid && !skid_valid. On accept, rr_ptr <= (granted index + 1) mod N; otherwise rr_ptr holds.
- Output handshake: pop = out_valid && out_ready.
- Register update, one edge per cycle:
  - pop and skid_valid: main <= skid; skid_valid <= 0. No accept is possible this cycle.
  - pop, no skid, accept: main <= accepted {data, src}; out_valid stays 1.
  - pop, no skid, no accept: out_valid <= 0.
  - No pop, main empty, accept: main <= accepted; out_valid <= 1.
  - No pop, main full, accept (so skid empty): skid <= accepted; skid_valid <= 1.
  - No pop, no accept: hold.
- Latency: an accepted item appears on out_valid the next cycle, provided main is empty or is being popped.
- Throughput: one item per cycle with out_ready=1 continuously. No bubbles, no lost or duplicated items.
- Ordering: items leave in acceptance order. The skid entry always leaves before anything newer.
- Stall: after out_ready drops with main full, at most one more item is accepted (into skid). in_ready then stays 0 until the skid drains.
- Fairness: a continuously valid requester is granted within N accepts.
- out_data and out_src are held stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards main and skid contents immediately. No partial handshake completes.
- in_valid bits for non-granted requesters have no effect. in_data of non-granted requesters is ignored.
- rr_ptr wraps from N-1 to 0.

Test Plan:
- Single requester, no backpressure: in_valid=4'b0100, data 0x0300..0x0307, out_ready=1 -> 8 outputs in order, out_src=2 each, one per cycle, first output 1 cycle after first accept.
- All four requesters continuously valid, out_ready=1: requester i sends 0x(i)000+k -> out_src sequence 0,1,2,3,0,1,... with no idle cycles; each stream's data stays in order.
- Backpressure: all requesters valid, out_ready=0 for 5 cycles starting with main full -> exactly 1 extra accept into skid, in_ready=0 for the remaining stalled cycles. When out_ready returns to 1 -> main item, then skid item, then the next grant, with no gap and no loss.
- Wrap and skip: rr_ptr=3, in_valid=4'b0011 -> grant requester 0 and rr_ptr becomes 1. Next cycle, same in_valid -> grant requester 1 and rr_ptr becomes 2.
- Asynchronous reset mid-stream: assert reset=0 between clock edges while main and skid are full -> out_valid=0 and in_ready=0 immediately. After release, the first grant goes to the lowest valid index (rr_ptr=0).
- Random stress: 70% in_valid per requester, 50% out_ready, 400 cycles. Scoreboard keyed by requester must match out_src and data in order, no starvation beyond N accepts, and produced count equals consumed count after drain.
